// File: rtl/quantile_host_pkg.sv
// Shared types and defaults for the quantile core host driver.
// The command word is {instr, data, rd} and is stored packed in the command FIFO.
package quantile_host_pkg;

    localparam int          QH_WORD_W     = 32;
    localparam logic [31:0] QH_NOP_INSTR  = 32'h0;
    localparam int          QH_RD_LATENCY = 2;
    localparam int          QH_CMD_DEPTH  = 4;
    localparam int          QH_RSP_DEPTH  = 4;

    typedef struct packed {
        logic [QH_WORD_W-1:0] instr;
        logic [QH_WORD_W-1:0] data;
        logic                 rd;
    } qh_cmd_t;

    localparam int QH_CMD_W = $bits(qh_cmd_t);

endpackage

// File: rtl/quantile_sync_fifo.sv
// Single-clock FIFO with occupancy count. The head word reads as zero while empty.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module quantile_sync_fifo
    import quantile_host_pkg::*;
#(
    parameter int WIDTH = QH_WORD_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full     = (cnt == FULL_CNT);
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/quantile_host_driver.sv
// Host-side initiator for the quantile core: queues commands, issues one per cycle,
// and returns read results through a credit-protected response FIFO.
module quantile_host_driver
    import quantile_host_pkg::*;
#(
    parameter int RD_LATENCY = QH_RD_LATENCY,
    parameter int CMD_DEPTH  = QH_CMD_DEPTH,
    parameter int RSP_DEPTH  = QH_RSP_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_instr,
    input  logic [31:0] cmd_data,
    input  logic        cmd_rd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [31:0] instruction,
    output logic [31:0] input_data,
    input  logic [31:0] output_data,
    output logic        busy
);

    qh_cmd_t                       cmd_in;
    qh_cmd_t                       cmd_head;
    logic [QH_CMD_W-1:0]           cmd_head_bits;
    logic                          cmd_full;
    logic                          cmd_empty;
    logic [$clog2(CMD_DEPTH):0]    cmd_count;
    logic                          rsp_full;
    logic                          rsp_empty;
    logic [$clog2(RSP_DEPTH):0]    rsp_count;
    logic [RD_LATENCY-1:0]         rd_tag_p;
    logic                          credit_blocked;
    logic                          issue_fire;
    logic                          issue_rd;
    logic                          rsp_push;

    function automatic int count_tags(input logic [RD_LATENCY-1:0] tags);
        int n;
        n = 0;
        for (int i = 0; i < RD_LATENCY; i++) n += int'(tags[i]);
        return n;
    endfunction

    assign cmd_in    = '{instr: cmd_instr, data: cmd_data, rd: cmd_rd};
    assign cmd_head  = qh_cmd_t'(cmd_head_bits);
    assign cmd_ready = !cmd_full;

    quantile_sync_fifo #(
        .WIDTH (QH_CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_valid && cmd_ready),
        .push_data (cmd_in),
        .pop       (issue_fire),
        .pop_data  (cmd_head_bits),
        .full      (cmd_full),
        .empty     (cmd_empty),
        .count     (cmd_count)
    );

    // Every tag in flight already owns a response slot, so a push can never find the FIFO full.
    assign credit_blocked = rsp_full ||
                            ((int'(rsp_count) + count_tags(rd_tag_p)) >= RSP_DEPTH);
    assign issue_fire     = !cmd_empty && !(cmd_head.rd && credit_blocked);
    assign issue_rd       = issue_fire && cmd_head.rd;

    // Issue stage: registered instruction/data plus the read tag entering the pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction <= QH_NOP_INSTR;
            input_data  <= '0;
            rd_tag_p    <= '0;
        end else begin
            if (issue_fire) begin
                instruction <= cmd_head.instr;
                input_data  <= cmd_head.data;
            end else begin
                instruction <= QH_NOP_INSTR;
                input_data  <= '0;
            end
            rd_tag_p[0] <= issue_rd;
            for (int i = 1; i < RD_LATENCY; i++) rd_tag_p[i] <= rd_tag_p[i-1];
        end
    end

    // Capture stage: a tag leaving the pipe samples the core result on this edge
    assign rsp_push = rd_tag_p[RD_LATENCY-1];

    quantile_sync_fifo #(
        .WIDTH (QH_WORD_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_push),
        .push_data (output_data),
        .pop       (rsp_ready),
        .pop_data  (rsp_data),
        .full      (rsp_full),
        .empty     (rsp_empty),
        .count     (rsp_count)
    );

    assign rsp_valid = !rsp_empty;
    assign busy      = (cmd_count != '0) || (|rd_tag_p);

endmodule

// File: doc/quantile_host_driver.md
# quantile_host_driver

Host-side driver for the quantile core's instruction interface: buffers host commands, issues one instruction per cycle onto `instruction`/`input_data`, and returns `output_data` words for read-type commands through a response channel. It sits between a host/bus adapter and the quantile core (directly or through the chip pad ring) and is the initiator for the core's instruction/data protocol.

## Interface
- `RD_LATENCY`, 2: edges from the issue edge of a read instruction to the edge where `output_data` holds its result; legal range is 1–8.
- `CMD_DEPTH`, 4: command FIFO entries; must be a power of 2 and ≥2.
- `RSP_DEPTH`, 4: response FIFO entries; must be a power of 2 and ≥2.
- `clk` in 1: single clock; everything is sampled on the rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `cmd_valid` in 1: host command valid.
- `cmd_ready` out 1: command FIFO not full.
- `cmd_instr` in 32: instruction word to issue.
- `cmd_data` in 32: scalar driven on `input_data` with the instruction.
- `cmd_rd` in 1: 1 means the instruction produces an `output_data` result to be returned.
- `rsp_valid` out 1: response FIFO not empty.
- `rsp_ready` in 1: host accepts the response.
- `rsp_data` out 32: head of the response FIFO.
- `instruction` out 32: registered, to the core.
- `input_data` out 32: registered, to the core.
- `output_data` in 32: from the core.
- `busy` out 1: any command queued, or any read still in flight.

## Operation
- The command handshake fires when `cmd_valid && cmd_ready` on an edge. The command is written as {instr, data, rd}.
- Issue stage, evaluated every cycle:
  - If the FIFO is non-empty and the head is not blocked, pop the head. On the edge, load `instruction`/`input_data` with it.
  - Otherwise, load the NOP: `instruction`=32'h0 and `input_data`=32'h0.
  - Instructions are never repeated. Each command is driven for exactly one cycle.
- Read tracking:
  - A shift register `RD_LATENCY` deep carries a read tag per issued slot.
  - When a tag reaches the end, `output_data` is sampled on that edge and pushed into the response FIFO.
- Credit rule:
  - A read head is blocked while `rsp_count + inflight_reads >= RSP_DEPTH`.
  - A write head (`cmd_rd`=0) is never blocked.
  - Order is strict: a blocked head stalls all commands behind it, and NOPs are issued meanwhile.
  - `rsp_count` is the occupancy before this edge's push/pop. A same-edge pop by the host frees credit only from the next cycle. Credit is conservative, so the response FIFO never overflows and captured data is never dropped.
- Simultaneous events:
  - Command push and issue pop on the same edge are legal, including when the FIFO is full: `cmd_ready` stays 0 when full, with no bypass.
  - Response push and host pop on the same edge are legal at any occupancy.
- Reset asserted at any time, including mid-operation:
  - Immediately clears both FIFOs and the tag pipeline.
  - Drives NOP on the outputs.
  - In-flight reads are discarded.
- Reset values: `instruction`=0, `input_data`=0, `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0, `busy`=0.

## Timing
- Command accepted on edge k into an empty, unblocked FIFO → on the outputs after edge k+1. Sustained rate is 1 instruction/cycle.
- Read issued on edge j → `output_data` sampled on edge j+`RD_LATENCY` → `rsp_valid`=1 after that edge.
- Total host-to-response latency for an idle block is `RD_LATENCY`+1 edges, plus 1 to the response handshake.
- `cmd_ready`, `rsp_valid`, `rsp_data` and `busy` are driven from registered state only, with no combinational path from `cmd_valid`/`rsp_ready`.
- `busy` falls on the edge after the last tag retires and the command FIFO is empty. It ignores pending responses.

## Structure
- Shared package `quantile_host_pkg` holds:
  - `QH_NOP_INSTR` = 32'h0 and the word width 32;
  - the command struct {instr[31:0], data[31:0], rd};
  - default depths and latency.
- Sub-module `quantile_sync_fifo` (parameters WIDTH, DEPTH; outputs full, empty, count) is instantiated twice: for commands (65 bits) and for responses (32 bits).
- Issue register, tag shift register, credit counter and `busy` logic live in the top.

## Test plan
- **Single write:** after reset, push {instr=32'h1234_0001, data=32'hDEAD_BEEF, rd=0} → `instruction`/`input_data` hold those values for exactly one cycle, one edge after acceptance. NOP before and after. `rsp_valid` never rises.
- **Single read:** push rd=1 with `RD_LATENCY`=2; the core model drives 32'hCAFE_0042 at the sampling edge → `rsp_data`=32'hCAFE_0042 with `rsp_valid` 3 edges after acceptance. `busy` is back to 0 afterwards.
- **Back-to-back burst:** push 4 writes, then 4 reads, each read returning its index → 8 consecutive issued cycles with no NOP gaps. Responses 0..3 arrive in order.
- **Response backpressure:**
  - Hold `rsp_ready`=0 and push 6 reads with `RSP_DEPTH`=4 → exactly 4 reads issue, then NOPs, and `cmd_ready` stays high until the FIFO fills.
  - Release `rsp_ready` → the remaining 2 reads issue and all 6 responses arrive in order, with no loss.
- **Full and simultaneous events:**
  - Fill the command FIFO (`cmd_ready`=0) while blocked, then unblock with `cmd_valid` held → push and pop occur on the same edge and no command is lost or duplicated.
- **Reset mid-read:** assert `rst_n`=0 one cycle after issuing a read → `instruction` is 0 immediately, `rsp_valid`=0, `busy`=0. After release, a new read returns only its own data.
